// File: rtl/bc_result_display.sv
// bc_result_display: latches bulls/cows results and sequences them onto one 7-segment digit
module bc_result_display #(
  parameter int DWELL = 10_000_000,
  parameter int GAP   = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  input  logic [2:0] bulls,
  input  logic [2:0] cows,
  input  logic       new_game,
  output logic [7:0] segment_out,
  output logic       busy
);
  localparam int MX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam int DL = DWELL - 1;
  localparam int GL = (GAP > 0) ? GAP - 1 : 0;
  typedef enum logic [3:0] {
    IDLE, B_LBL, B_VAL, GAP_B, C_LBL, C_VAL, GAP_C, WIN_ON, WIN_OFF, ERR
  } state_t;
  state_t        state_q, state_d, succ, entry;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bulls_q, bulls_d, cows_q, cows_d;
  logic [7:0]    seg_d;
  logic          lim_hit, bad;
  function automatic logic [7:0] digit(input logic [2:0] v);
    return v == 3'd0 ? 8'h3F : v == 3'd1 ? 8'h06 : v == 3'd2 ? 8'h5B :
           v == 3'd3 ? 8'h4F : v == 3'd4 ? 8'h66 : 8'h00;
  endfunction
  // State, dwell counter, latched score and registered segment output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bulls_q     <= '0;
      cows_q      <= '0;
      segment_out <= 8'h40;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bulls_q     <= bulls_d;
      cows_q      <= cows_d;
      segment_out <= seg_d;
    end
  end
  // Next state: new_game beats a result, a result beats the dwell timer
  always_comb begin
    bad     = bulls > 3'd4 || cows > 3'd4 || ({1'b0, bulls} + {1'b0, cows}) > 4'd4;
    entry   = bad ? ERR : bulls == 3'd4 ? WIN_ON : B_LBL;
    lim_hit = (state_q == GAP_B || state_q == GAP_C) ? cnt_q == CW'(GL) : cnt_q == CW'(DL);
    case (state_q)
      B_LBL:   succ = B_VAL;
      B_VAL:   succ = (GAP == 0) ? C_LBL : GAP_B;
      GAP_B:   succ = C_LBL;
      C_LBL:   succ = C_VAL;
      C_VAL:   succ = (GAP == 0) ? B_LBL : GAP_C;
      GAP_C:   succ = B_LBL;
      WIN_ON:  succ = WIN_OFF;
      WIN_OFF: succ = WIN_ON;
      default: succ = state_q;
    endcase
    state_d = new_game ? IDLE : res_valid ? entry : lim_hit ? succ : state_q;
    bulls_d = new_game ? 3'd0 : res_valid ? bulls : bulls_q;
    cows_d  = new_game ? 3'd0 : res_valid ? cows : cows_q;
    cnt_d   = (new_game || res_valid || state_d != state_q || state_q == IDLE || state_q == ERR)
              ? '0 : cnt_q + 1'b1;
  end
  // Segment pattern for the state being entered, so output moves with the state
  always_comb begin
    case (state_d)
      B_LBL:   seg_d = 8'h7C;
      B_VAL:   seg_d = digit(bulls_d);
      C_LBL:   seg_d = 8'h39;
      C_VAL:   seg_d = digit(cows_d);
      WIN_ON:  seg_d = 8'hFF;
      ERR:     seg_d = 8'h79;
      IDLE:    seg_d = 8'h40;
      default: seg_d = 8'h00;
    endcase
  end
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_bc_result_display.sv
// tb_bc_result_display: directed checks of the result display sequencer
module tb_bc_result_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       res_valid = 1'b0;
  logic [2:0] bulls = '0;
  logic [2:0] cows = '0;
  logic       new_game = 1'b0;
  logic [7:0] seg, seg0;
  logic       busy, busy0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bc_result_display #(.DWELL(4), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .bulls(bulls), .cows(cows),
    .new_game(new_game), .segment_out(seg), .busy(busy));

  bc_result_display #(.DWELL(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .bulls(bulls), .cows(cows),
    .new_game(new_game), .segment_out(seg0), .busy(busy0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input bit g0, input logic [7:0] exp,
                     input logic exp_busy, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, g0 ? seg0 : seg, exp);
      chk({tag, "_busy"}, {7'd0, g0 ? busy0 : busy}, {7'd0, exp_busy});
      step();
    end
  endtask

  task automatic pulse(input logic [2:0] b, input logic [2:0] c);
    res_valid = 1'b1;
    bulls = b;
    cows = c;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    step();
    run("reset", 0, 8'h40, 1'b0, 10);
    rst_n = 1'b1;
    run("idle", 0, 8'h40, 1'b0, 3);
    pulse(3'd1, 3'd2);
    run("b_lbl", 0, 8'h7C, 1'b1, 4);
    run("b_val", 0, 8'h06, 1'b1, 4);
    run("gap_b", 0, 8'h00, 1'b1, 2);
    run("c_lbl", 0, 8'h39, 1'b1, 4);
    run("c_val", 0, 8'h5B, 1'b1, 4);
    run("gap_c", 0, 8'h00, 1'b1, 2);
    run("b_lbl2", 0, 8'h7C, 1'b1, 4);
    pulse(3'd4, 3'd0);
    run("win_on", 0, 8'hFF, 1'b1, 4);
    run("win_off", 0, 8'h00, 1'b1, 4);
    run("win_on2", 0, 8'hFF, 1'b1, 4);
    pulse(3'd3, 3'd2);
    run("err_sum", 0, 8'h79, 1'b1, 6);
    pulse(3'd5, 3'd0);
    run("err_bulls", 0, 8'h79, 1'b1, 3);
    pulse(3'd0, 3'd1);
    run("r_b_lbl", 0, 8'h7C, 1'b1, 4);
    run("r_b_val", 0, 8'h3F, 1'b1, 3);
    pulse(3'd2, 3'd2);
    run("r2_b_lbl", 0, 8'h7C, 1'b1, 4);
    run("r2_b_val", 0, 8'h5B, 1'b1, 4);
    run("r2_gap_b", 0, 8'h00, 1'b1, 2);
    run("r2_c_lbl", 0, 8'h39, 1'b1, 4);
    run("r2_c_val", 0, 8'h5B, 1'b1, 1);
    new_game = 1'b1;
    pulse(3'd1, 3'd1);
    new_game = 1'b0;
    run("ng_idle", 0, 8'h40, 1'b0, 6);
    pulse(3'd1, 3'd0);
    run("rst_mid", 0, 8'h7C, 1'b1, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run("rst_abort", 0, 8'h40, 1'b0, 3);
    pulse(3'd0, 3'd0);
    run("g0_b_lbl", 1, 8'h7C, 1'b1, 4);
    run("g0_b_val", 1, 8'h3F, 1'b1, 4);
    run("g0_c_lbl", 1, 8'h39, 1'b1, 4);
    run("g0_c_val", 1, 8'h3F, 1'b1, 4);
    run("g0_wrap", 1, 8'h7C, 1'b1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
